// File: rtl/aes_pkg.sv
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions for the iterative cipher core.
//                Holds the forward S-box table, the GF(2^8) xtime helper,
//                the cipher FSM state type, the AES column count and a
//                helper that maps a round-key index to its bit position in
//                the flattened key schedule.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  // Number of 32-bit columns in the AES state.
  localparam int c_NB = 4;

  // Forward S-box, entry 0 in the MSBs, one row of 16 entries per literal.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Cipher control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_t;

  // Byte substitution through the table above.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MSB position of round key idx in a schedule built for nk key words.
  // Key 0 occupies the top 128 bits; use with a -: 128 part select.
  function automatic int rk_msb(input int nk, input int idx);
    return 128 * (7 + nk) - 128 * idx - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mix_column.sv
// ============================================================================
//  Module      : aes_mix_column
//  Description : AES MixColumns transform for one 32-bit state column.
//                Byte 0 of the column is in the MSBs.
//  Ports       : i_col  [31:0]  input column  (a0 a1 a2 a3)
//                o_col  [31:0]  output column (b0 b1 b2 b3)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0;
  logic [7:0] w_a1;
  logic [7:0] w_a2;
  logic [7:0] w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // Circulant matrix {02 03 01 01}; 3*a is expressed as xtime(a) ^ a.
  assign o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
  assign o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule

`default_nettype wire

// File: rtl/aes_cipher_core.sv
// ============================================================================
//  Module      : aes_cipher_core
//  Description : Iterative AES encryption core, one round per clock, one
//                block in flight. Consumes a precomputed, flattened round-key
//                schedule (key 0 in the MSBs).
//  Parameters  : NK  key length in 32-bit words (4/6/8); Nr = NK + 6
//  Ports       : clk            clock, rising edge
//                reset          synchronous active-high reset
//                i_key_ready    schedule complete and round keys stable
//                i_round_keys   128*(7+NK) flattened round keys
//                i_in_valid     plaintext offered
//                o_in_ready     core can accept plaintext
//                i_plaintext    128-bit block, byte 0 in [127:120]
//                o_out_valid    ciphertext available (held until taken)
//                i_out_ready    consumer takes ciphertext
//                o_ciphertext   128-bit block, same byte order
//  Options     : AES_ROUND_DBG_EN adds o_dbg_round (current round, 0 when
//                not encrypting) and o_dbg_state (working state register).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_key_ready,
  input  logic [128*(7+NK)-1:0] i_round_keys,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [127:0]          i_plaintext,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [127:0]          o_ciphertext
`ifdef AES_ROUND_DBG_EN
  ,
  output logic [3:0]            o_dbg_round,
  output logic [127:0]          o_dbg_state
`endif
);

  localparam int         c_NR    = NK + 6;
  localparam int         c_NKEYS = c_NR + 1;
  localparam logic [3:0] c_NR_W  = 4'(c_NR);

  aes_state_t   r_state;
  aes_state_t   w_state_nxt;
  logic [127:0] r_state_reg;
  logic [3:0]   r_rnd;
  logic         r_out_valid;
  logic [127:0] r_ciphertext;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_last;
  logic [127:0] w_rk [c_NKEYS];
  logic [127:0] w_round_key;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_next;

  // --------------------------------------------------------------------------
  // Round-key selection
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < c_NKEYS; k++) begin : g_rk
    assign w_rk[k] = i_round_keys[rk_msb(NK, k) -: 128];
  end

  assign w_round_key = w_rk[r_rnd];

  // --------------------------------------------------------------------------
  // Round datapath: SubBytes + ShiftRows fused. Output byte (row r, col c)
  // comes from input column (c + r) mod 4 of the same row.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < c_NB; r++) begin : g_row
    for (genvar c = 0; c < c_NB; c++) begin : g_col
      localparam int c_SRC = r + c_NB * ((c + r) % c_NB);
      assign w_sr[127 - 8*(r + c_NB*c) -: 8] = sbox(r_state_reg[127 - 8*c_SRC -: 8]);
    end
  end

  for (genvar c = 0; c < c_NB; c++) begin : g_mix
    aes_mix_column u_mix (
      .i_col (w_sr[127 - 32*c -: 32]),
      .o_col (w_mc[127 - 32*c -: 32])
    );
  end

  // The final round omits MixColumns.
  assign w_last = (r_rnd == c_NR_W);
  assign w_next = (w_last ? w_sr : w_mc) ^ w_round_key;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        // Losing the key schedule mid-block abandons the block.
        if (!i_key_ready) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // Held low during reset so the reset-state outputs are all zero.
    w_in_ready = (r_state == ST_IDLE) && i_key_ready && !reset;
  end

  assign w_accept     = i_in_valid && w_in_ready;
  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_ciphertext = r_ciphertext;

`ifdef AES_ROUND_DBG_EN
  assign o_dbg_round = (r_state == ST_ROUND) ? r_rnd : 4'd0;
  assign o_dbg_state = r_state_reg;
`endif

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg  <= '0;
      r_rnd        <= 4'd0;
      r_out_valid  <= 1'b0;
      r_ciphertext <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state_reg <= i_plaintext ^ w_rk[0];
            r_rnd       <= 4'd1;
          end
        end
        ST_ROUND: begin
          if (!i_key_ready) begin
            r_state_reg <= '0;
            r_rnd       <= 4'd0;
          end else begin
            r_state_reg <= w_next;
            if (w_last) begin
              // Counter parks at 0 so it never runs past Nr.
              r_rnd        <= 4'd0;
              r_out_valid  <= 1'b1;
              r_ciphertext <= w_next;
            end else begin
              r_rnd <= r_rnd + 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_rnd <= 4'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
